// File: rtl/riscv_operand_fetch.sv
// Operand-fetch stage: regfile read, EX/WB bypass, load-use scoreboard, registered EX handoff.
// Define RISCV_OPFETCH_PERF_EN to add the perf_stall_cycles_out hazard-stall counter.
module riscv_operand_fetch #(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            flush_in,

    input  logic            dec_valid_in,
    output logic            dec_ready_out,
    input  logic [31:0]     dec_pc_in,
    input  logic [4:0]      dec_ra_in,
    input  logic [4:0]      dec_rb_in,
    input  logic [4:0]      dec_rd_in,
    input  logic            dec_uses_ra_in,
    input  logic            dec_uses_rb_in,
    input  logic            dec_writes_rd_in,
    input  logic            dec_is_load_in,

    output logic [4:0]      rf_ra_out,
    output logic [4:0]      rf_rb_out,
    input  logic [XLEN-1:0] rf_rd1_in,
    input  logic [XLEN-1:0] rf_rd2_in,

    input  logic            ex_fwd_valid_in,
    input  logic [4:0]      ex_fwd_rd_in,
    input  logic [XLEN-1:0] ex_fwd_data_in,

    input  logic            wb_we_in,
    input  logic [4:0]      wb_rd_in,
    input  logic [XLEN-1:0] wb_wd_in,
    input  logic            wb_load_done_in,

    output logic            ex_valid_out,
    input  logic            ex_ready_in,
    output logic [31:0]     ex_pc_out,
    output logic [XLEN-1:0] ex_op1_out,
    output logic [XLEN-1:0] ex_op2_out,
    output logic [4:0]      ex_rd_out,
    output logic            ex_writes_rd_out,
    output logic            ex_is_load_out
`ifdef RISCV_OPFETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles_out
`endif
);

    // Handshake: a transfer happens on a cycle where valid && ready; the producer
    // holds valid and payload stable until then, and ready never depends on valid.

    logic [31:0]     scoreboard;
    logic [31:0]     scoreboard_next;
    logic            hazard_a;
    logic            hazard_b;
    logic            hazard;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            capture;
    logic            handoff;

    assign rf_ra_out = dec_ra_in;
    assign rf_rb_out = dec_rb_in;

    // Youngest producer wins: EX result, then the WB write not yet in the regfile.
    always_comb begin
        op1 = rf_rd1_in;
        if (!dec_uses_ra_in || dec_ra_in == 5'd0) begin
            op1 = '0;
        end else if (ex_fwd_valid_in && ex_fwd_rd_in == dec_ra_in) begin
            op1 = ex_fwd_data_in;
        end else if (wb_we_in && wb_rd_in == dec_ra_in) begin
            op1 = wb_wd_in;
        end
    end

    always_comb begin
        op2 = rf_rd2_in;
        if (!dec_uses_rb_in || dec_rb_in == 5'd0) begin
            op2 = '0;
        end else if (ex_fwd_valid_in && ex_fwd_rd_in == dec_rb_in) begin
            op2 = ex_fwd_data_in;
        end else if (wb_we_in && wb_rd_in == dec_rb_in) begin
            op2 = wb_wd_in;
        end
    end

    // A source waits on an outstanding load, or on a producer still sitting in our output register.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        if (dec_uses_ra_in && dec_ra_in != 5'd0) begin
            hazard_a = (scoreboard[dec_ra_in] && !(wb_load_done_in && wb_rd_in == dec_ra_in))
                    || (ex_valid_out && ex_writes_rd_out && ex_rd_out == dec_ra_in);
        end
        if (dec_uses_rb_in && dec_rb_in != 5'd0) begin
            hazard_b = (scoreboard[dec_rb_in] && !(wb_load_done_in && wb_rd_in == dec_rb_in))
                    || (ex_valid_out && ex_writes_rd_out && ex_rd_out == dec_rb_in);
        end
    end

    assign hazard        = hazard_a || hazard_b;
    assign dec_ready_out = !rst_in && !flush_in && !hazard && (!ex_valid_out || ex_ready_in);
    assign capture       = dec_valid_in && dec_ready_out;
    assign handoff       = ex_valid_out && ex_ready_in && !flush_in;

    // Set is applied after clear so a same-cycle set of the same index wins.
    always_comb begin
        scoreboard_next = scoreboard;
        if (wb_load_done_in && wb_we_in) begin
            scoreboard_next[wb_rd_in] = 1'b0;
        end
        if (handoff && ex_is_load_out && ex_writes_rd_out && ex_rd_out != 5'd0) begin
            scoreboard_next[ex_rd_out] = 1'b1;
        end
        scoreboard_next[0] = 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            scoreboard <= '0;
        end else begin
            scoreboard <= scoreboard_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ex_valid_out     <= 1'b0;
            ex_pc_out        <= '0;
            ex_op1_out       <= '0;
            ex_op2_out       <= '0;
            ex_rd_out        <= '0;
            ex_writes_rd_out <= 1'b0;
            ex_is_load_out   <= 1'b0;
        end else if (flush_in) begin
            ex_valid_out <= 1'b0;
        end else if (capture) begin
            ex_valid_out     <= 1'b1;
            ex_pc_out        <= dec_pc_in;
            ex_op1_out       <= op1;
            ex_op2_out       <= op2;
            ex_rd_out        <= dec_rd_in;
            ex_writes_rd_out <= dec_writes_rd_in;
            ex_is_load_out   <= dec_is_load_in;
        end else if (ex_valid_out && ex_ready_in) begin
            ex_valid_out <= 1'b0;
        end
    end

`ifdef RISCV_OPFETCH_PERF_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_stall_cycles_out <= '0;
        end else if (dec_valid_in && hazard && !flush_in) begin
            perf_stall_cycles_out <= perf_stall_cycles_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_operand_fetch.sv
// Self-checking bench for riscv_operand_fetch: directed scenarios, then random traffic
// checked against a queue-based reference model of the bypass/scoreboard rules.
module tb_riscv_operand_fetch;

    localparam int XLEN = 32;

    logic            clk_in;
    logic            rst_in;
    logic            flush_in;
    logic            dec_valid_in;
    logic            dec_ready_out;
    logic [31:0]     dec_pc_in;
    logic [4:0]      dec_ra_in;
    logic [4:0]      dec_rb_in;
    logic [4:0]      dec_rd_in;
    logic            dec_uses_ra_in;
    logic            dec_uses_rb_in;
    logic            dec_writes_rd_in;
    logic            dec_is_load_in;
    logic [4:0]      rf_ra_out;
    logic [4:0]      rf_rb_out;
    logic [XLEN-1:0] rf_rd1_in;
    logic [XLEN-1:0] rf_rd2_in;
    logic            ex_fwd_valid_in;
    logic [4:0]      ex_fwd_rd_in;
    logic [XLEN-1:0] ex_fwd_data_in;
    logic            wb_we_in;
    logic [4:0]      wb_rd_in;
    logic [XLEN-1:0] wb_wd_in;
    logic            wb_load_done_in;
    logic            ex_valid_out;
    logic            ex_ready_in;
    logic [31:0]     ex_pc_out;
    logic [XLEN-1:0] ex_op1_out;
    logic [XLEN-1:0] ex_op2_out;
    logic [4:0]      ex_rd_out;
    logic            ex_writes_rd_out;
    logic            ex_is_load_out;
`ifdef RISCV_OPFETCH_PERF_EN
    logic [31:0]     perf_stall_cycles_out;
    logic [31:0]     m_perf;
`endif

    riscv_operand_fetch #(.XLEN(XLEN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out), .dec_pc_in(dec_pc_in),
        .dec_ra_in(dec_ra_in), .dec_rb_in(dec_rb_in), .dec_rd_in(dec_rd_in),
        .dec_uses_ra_in(dec_uses_ra_in), .dec_uses_rb_in(dec_uses_rb_in),
        .dec_writes_rd_in(dec_writes_rd_in), .dec_is_load_in(dec_is_load_in),
        .rf_ra_out(rf_ra_out), .rf_rb_out(rf_rb_out), .rf_rd1_in(rf_rd1_in), .rf_rd2_in(rf_rd2_in),
        .ex_fwd_valid_in(ex_fwd_valid_in), .ex_fwd_rd_in(ex_fwd_rd_in), .ex_fwd_data_in(ex_fwd_data_in),
        .wb_we_in(wb_we_in), .wb_rd_in(wb_rd_in), .wb_wd_in(wb_wd_in), .wb_load_done_in(wb_load_done_in),
        .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready_in), .ex_pc_out(ex_pc_out),
        .ex_op1_out(ex_op1_out), .ex_op2_out(ex_op2_out), .ex_rd_out(ex_rd_out),
        .ex_writes_rd_out(ex_writes_rd_out), .ex_is_load_out(ex_is_load_out)
`ifdef RISCV_OPFETCH_PERF_EN
        , .perf_stall_cycles_out(perf_stall_cycles_out)
`endif
    );

    // ---------------- clock ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    int              n_cmp = 0;
    int              n_bad = 0;
    int              pend_q[$];
    logic            m_valid;
    logic [31:0]     m_pc;
    logic [XLEN-1:0] m_op1;
    logic [XLEN-1:0] m_op2;
    logic [4:0]      m_rd;
    logic            m_writes;
    logic            m_load;
    logic            exp_ready;
    logic            exp_stall;

    function automatic bit pending(input logic [4:0] r);
        foreach (pend_q[i]) if (pend_q[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] m_operand(input logic [4:0] idx, input logic used,
                                                  input logic [XLEN-1:0] rf);
        if (idx == 5'd0 || !used) return '0;
        if (ex_fwd_valid_in && ex_fwd_rd_in == idx) return ex_fwd_data_in;
        if (wb_we_in && wb_rd_in == idx) return wb_wd_in;
        return rf;
    endfunction

    function automatic bit m_src_stall(input logic [4:0] idx, input logic used);
        if (!used || idx == 5'd0) return 1'b0;
        if (pending(idx) && !(wb_load_done_in && wb_rd_in == idx)) return 1'b1;
        return m_valid && m_writes && m_rd == idx;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        rst_in = 1'b0; flush_in = 1'b0; dec_valid_in = 1'b0; dec_pc_in = '0;
        dec_ra_in = '0; dec_rb_in = '0; dec_rd_in = '0; dec_uses_ra_in = 1'b0; dec_uses_rb_in = 1'b0;
        dec_writes_rd_in = 1'b0; dec_is_load_in = 1'b0; rf_rd1_in = '0; rf_rd2_in = '0;
        ex_fwd_valid_in = 1'b0; ex_fwd_rd_in = '0; ex_fwd_data_in = '0;
        wb_we_in = 1'b0; wb_rd_in = '0; wb_wd_in = '0; wb_load_done_in = 1'b0; ex_ready_in = 1'b1;
    endtask

    task automatic set_inst(input logic [31:0] pc, input logic [4:0] ra, input logic ua,
                            input logic [4:0] rb, input logic ub, input logic [4:0] rd,
                            input logic wr, input logic ld);
        dec_valid_in = 1'b1; dec_pc_in = pc; dec_ra_in = ra; dec_uses_ra_in = ua;
        dec_rb_in = rb; dec_uses_rb_in = ub; dec_rd_in = rd; dec_writes_rd_in = wr; dec_is_load_in = ld;
    endtask

    // Combinational checks, a little after the inputs change.
    task automatic settle();
        #1;
        exp_stall = m_src_stall(dec_ra_in, dec_uses_ra_in) || m_src_stall(dec_rb_in, dec_uses_rb_in);
        exp_ready = !rst_in && !flush_in && !exp_stall && (!m_valid || ex_ready_in);
        check("dec_ready", 128'(dec_ready_out), 128'(exp_ready));
        check("rf_addr", 128'({rf_ra_out, rf_rb_out}), 128'({dec_ra_in, dec_rb_in}));
    endtask

    // Advance the model with the pre-edge inputs, clock, then check the registered outputs.
    task automatic clock();
        bit capture;
        bit handoff;
        if (rst_in) begin
            m_valid = 1'b0; m_pc = '0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_writes = 1'b0; m_load = 1'b0;
            pend_q.delete();
`ifdef RISCV_OPFETCH_PERF_EN
            m_perf = '0;
`endif
        end else begin
            capture = dec_valid_in && exp_ready;
            handoff = m_valid && ex_ready_in && !flush_in;
`ifdef RISCV_OPFETCH_PERF_EN
            if (dec_valid_in && exp_stall && !flush_in) m_perf = m_perf + 32'd1;
`endif
            if (wb_load_done_in && wb_we_in)
                for (int i = pend_q.size() - 1; i >= 0; i--)
                    if (pend_q[i] == int'(wb_rd_in)) pend_q.delete(i);
            if (handoff && m_load && m_writes && m_rd != 5'd0 && !pending(m_rd))
                pend_q.push_back(int'(m_rd));
            if (flush_in) begin
                m_valid = 1'b0;
            end else if (capture) begin
                m_valid = 1'b1; m_pc = dec_pc_in; m_rd = dec_rd_in;
                m_op1 = m_operand(dec_ra_in, dec_uses_ra_in, rf_rd1_in);
                m_op2 = m_operand(dec_rb_in, dec_uses_rb_in, rf_rd2_in);
                m_writes = dec_writes_rd_in; m_load = dec_is_load_in;
            end else if (m_valid && ex_ready_in) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk_in);
        #1;
        check("ex_valid", 128'(ex_valid_out), 128'(m_valid));
        if (m_valid)
            check("ex_fields",
                  128'({ex_pc_out, ex_op1_out, ex_op2_out, ex_rd_out, ex_writes_rd_out, ex_is_load_out}),
                  128'({m_pc, m_op1, m_op2, m_rd, m_writes, m_load}));
`ifdef RISCV_OPFETCH_PERF_EN
        check("perf", 128'(perf_stall_cycles_out), 128'(m_perf));
`endif
    endtask

    task automatic tick();
        settle();
        clock();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        m_valid = 1'b0; m_pc = '0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_writes = 1'b0; m_load = 1'b0;
`ifdef RISCV_OPFETCH_PERF_EN
        m_perf = '0;
`endif
        drive_idle();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        check("reset_state",
              128'({ex_valid_out, ex_pc_out, ex_op1_out, ex_op2_out, ex_rd_out, ex_writes_rd_out, ex_is_load_out}),
              128'(0));

        // Plain regfile read.
        set_inst(32'h100, 5'd5, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0);
        rf_rd1_in = 32'h1234;
        tick();
        check("rf_read_valid", 128'(ex_valid_out), 128'(1));
        check("rf_read_op1", 128'(ex_op1_out), 128'(32'h1234));
        drive_idle(); tick();

        // EX bypass beats WB bypass; WB alone beats the regfile.
        set_inst(32'h200, 5'd5, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0);
        rf_rd1_in = 32'h1111; ex_fwd_valid_in = 1'b1; ex_fwd_rd_in = 5'd5; ex_fwd_data_in = 32'hAAAA;
        wb_we_in = 1'b1; wb_rd_in = 5'd5; wb_wd_in = 32'hBBBB;
        tick();
        check("ex_fwd_prio", 128'(ex_op1_out), 128'(32'hAAAA));
        ex_fwd_valid_in = 1'b0; dec_pc_in = 32'h204;
        tick();
        check("wb_fwd", 128'(ex_op1_out), 128'(32'hBBBB));
        drive_idle(); tick();

        // Load-use: reader of x7 waits for the load completion, then takes WB data.
        set_inst(32'h300, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        set_inst(32'h304, 5'd7, 1'b1, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0);
        rf_rd1_in = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("load_use_stall", 128'(dec_ready_out), 128'(0));
            clock();
        end
        wb_we_in = 1'b1; wb_rd_in = 5'd7; wb_wd_in = 32'h55; wb_load_done_in = 1'b1;
        settle();
        check("load_done_ready", 128'(dec_ready_out), 128'(1));
        clock();
        check("load_done_op1", 128'({ex_valid_out, ex_op1_out}), 128'({1'b1, 32'h55}));
        drive_idle(); tick();

        // Downstream back-pressure holds the entry; release captures the waiting instruction.
        set_inst(32'h400, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        rf_rd1_in = 32'hA1;
        tick();
        set_inst(32'h410, 5'd2, 1'b1, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0);
        rf_rd1_in = 32'hB2; ex_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_ready", 128'(dec_ready_out), 128'(0));
            clock();
            check("stall_hold", 128'({ex_valid_out, ex_pc_out, ex_op1_out, ex_rd_out}),
                  128'({1'b1, 32'h400, 32'hA1, 5'd3}));
        end
        ex_ready_in = 1'b1;
        tick();
        check("release_capture", 128'({ex_valid_out, ex_pc_out, ex_op1_out}), 128'({1'b1, 32'h410, 32'hB2}));
        drive_idle(); tick();

        // x0 is never bypassed and never stalls.
        set_inst(32'h500, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0);
        rf_rd1_in = 32'h1234; ex_fwd_valid_in = 1'b1; ex_fwd_rd_in = 5'd0; ex_fwd_data_in = 32'hFFFF;
        wb_we_in = 1'b1; wb_rd_in = 5'd0; wb_wd_in = 32'hEEEE;
        tick();
        check("x0_zero", 128'(ex_op1_out), 128'(0));
        drive_idle();
        set_inst(32'h510, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_inst(32'h514, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b0, 1'b0);
        settle();
        check("x0_no_stall_a", 128'(dec_ready_out), 128'(1));
        clock();
        dec_pc_in = 32'h518;
        settle();
        check("x0_no_stall_b", 128'(dec_ready_out), 128'(1));
        clock();
        drive_idle(); tick();

        // Flushed load never marks its destination busy.
        set_inst(32'h600, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        set_inst(32'h604, 5'd9, 1'b1, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0);
        flush_in = 1'b1;
        settle();
        check("flush_ready", 128'(dec_ready_out), 128'(0));
        clock();
        check("flush_kill", 128'(ex_valid_out), 128'(0));
        flush_in = 1'b0;
        settle();
        check("flush_no_sb", 128'(dec_ready_out), 128'(1));
        clock();
        check("flush_reader", 128'({ex_valid_out, ex_pc_out}), 128'({1'b1, 32'h604}));
        drive_idle(); tick();

        // Reset while stalled drops the pending entry.
        set_inst(32'h700, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        ex_ready_in = 1'b0; dec_valid_in = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();
        check("reset_mid_stall", 128'(ex_valid_out), 128'(0));
        drive_idle(); tick();

        // Random traffic over a small register window so hazards are frequent.
        for (int n = 0; n < 600; n++) begin
            rst_in = ($urandom_range(0, 79) == 0);
            flush_in = ($urandom_range(0, 15) == 0);
            set_inst($urandom, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                     1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 2) == 0));
            dec_valid_in = ($urandom_range(0, 3) != 0);
            rf_rd1_in = $urandom; rf_rd2_in = $urandom;
            ex_fwd_valid_in = 1'($urandom); ex_fwd_rd_in = 5'($urandom_range(0, 7)); ex_fwd_data_in = $urandom;
            wb_we_in = 1'($urandom); wb_rd_in = 5'($urandom_range(0, 7)); wb_wd_in = $urandom;
            wb_load_done_in = ($urandom_range(0, 2) == 0);
            ex_ready_in = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
